alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream issue stage for the R0 ALU multiplexer: accepts one ALU op (opcode + two 8-bit operands),
//  drives the multiplexer's en/state/value1/value2, holds them stable until ready, captures Output1/Output2.
//  Presents a clean 16-bit result and a one-cycle done pulse to the control unit; never forwards X.
// PARAMETERS
//  DATA_W          8    operand width; result is 2*DATA_W
//  TIMEOUT_CYCLES  64   max WAIT cycles before abort (used only with ALU_SEQ_TIMEOUT_EN)
// PORTS
//  clk         in   1         single clock, all logic on posedge
//  reset       in   1         synchronous, active-high
//  start       in   1         request; accepted only when busy=0
//  opcode      in   2         0=ADD 1=SUB 2=MUL 3=NEG
//  operand_a   in   DATA_W    first operand (value1)
//  operand_b   in   DATA_W    second operand (value2; ignored for NEG)
//  mux_out1    in   DATA_W    multiplexer Output1
//  mux_out2    in   DATA_W    multiplexer Output2 (valid for MUL only)
//  mux_ready   in   1         multiplexer ready
//  mux_en      out  1         multiplexer enable
//  mux_state   out  2         multiplexer op select
//  mux_value1  out  DATA_W    latched operand_a
//  mux_value2  out  DATA_W    latched operand_b
//  busy        out  1         op in flight (ISSUE/WAIT/DONE/ERR)
//  done        out  1         one-cycle completion pulse
//  result_hi   out  DATA_W    upper result byte
//  result_lo   out  DATA_W    lower result byte
//  error       out  1         timeout flag (tied 0 without macro)
// BEHAVIOUR
//  Reset: state=IDLE; mux_en, busy, done, error, result_hi, result_lo, mux_value1/2, mux_state all 0.
//  Reset mid-op: same, next cycle; in-flight op discarded, no done pulse.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE; WAIT -> ERR -> IDLE (timeout only).
//  IDLE : mux_en=0. start=1 latches opcode/operands into mux_state/mux_value1/2, go ISSUE.
//  ISSUE: mux_en=1, busy=1; mux_ready ignored this cycle (masks stale ready from a prior op). Go WAIT.
//  WAIT : mux_en=1; first cycle mux_ready=1 captures results, go DONE.
//  Capture: MUL -> result_hi=mux_out1, result_lo=mux_out2; ADD/SUB/NEG -> result_lo=mux_out1, result_hi=0.
//  DONE : mux_en=0, done=1 for exactly this cycle, results valid; go IDLE.
//  Results hold until the next capture or reset; never updated from X-driven Output2.
//  mux_value1/2 and mux_state are constant from ISSUE through DONE.
//  start while busy=1 is ignored (not queued). Min start-to-done: ISSUE+WAIT+DONE = done 3 cycles after
//  the start cycle if ready is seen in the first WAIT cycle.
//  mux_en is low >= 2 cycles (DONE+IDLE) between ops so multiplexer ready clears.
//  Arithmetic is done by the multiplexer; this block does no math, no width change except zero-fill of result_hi.
// CONFIGURATION
//  ALU_SEQ_TIMEOUT_EN defined: counter counts WAIT cycles; reaching TIMEOUT_CYCLES without ready -> ERR:
//   mux_en=0, done=1 (one cycle), error=1, results unchanged; go IDLE. error is sticky until the next
//   accepted start or reset. Covers unimplemented ops (e.g. MUL unit absent).
//  Not defined: WAIT persists until ready or reset; error tied to 0; no counter logic.
// STRUCTURE
//  Shared header alu_defs.vh: opcode localparams ALU_ADD/ALU_SUB/ALU_MUL/ALU_NEG, FSM state encodings,
//   DATA_W default; also included by the multiplexer.
//  One sub-module: alu_seq_watchdog (clear/enable/expired counter), instantiated only under ALU_SEQ_TIMEOUT_EN.
// TESTING
//  Bench uses a behavioural multiplexer model with programmable ready latency.
//  ADD a=100 b=27, ready after 2 WAIT cycles -> done pulse, result_hi=0 result_lo=127, error=0.
//  SUB a=50 b=20 then NEG a=5 back-to-back -> results 0/30 then 0/251; mux_en low >= 2 cycles between.
//  MUL a=16 b=16, model Output1=1 Output2=0 -> result_hi=1 result_lo=0; ADD Output2=X -> result_hi=0, no X.
//  Stale ready: model holds mux_ready=1 at ISSUE -> ignored; capture only from WAIT.
//  start pulsed during WAIT with new operands -> ignored; mux_value1/2 unchanged; one done only.
//  Macro on, TIMEOUT_CYCLES=8, ready never asserted -> done+error=1 after 8 WAIT cycles; next start clears error.
//  reset in WAIT -> next cycle all outputs 0, state IDLE, no done pulse.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: shared opcode, FSM state and width definitions for the ALU op sequencer
package alu_op_sequencer_pkg;

    localparam int ALU_DATA_W = 8;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_MUL = 2'd2;
    localparam logic [1:0] ALU_NEG = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    function automatic logic is_mul(input logic [1:0] op);
        return op == ALU_MUL;
    endfunction

endpackage

// File: rtl/alu_seq_watchdog.sv
// alu_seq_watchdog: WAIT-cycle counter that flags expiry after LIMIT cycles (built only with ALU_SEQ_TIMEOUT_EN)
`ifdef ALU_SEQ_TIMEOUT_EN
module alu_seq_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    assign expired = enable && cnt == CW'(LIMIT - 1);

    // count enabled cycles, restart whenever cleared
    always_ff @(posedge clk) begin
        if (reset || clear) cnt <= '0;
        else if (enable && !expired) cnt <= cnt + 1'b1;
    end
endmodule
`endif

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one op to the ALU multiplexer and returns a clean result; ALU_SEQ_TIMEOUT_EN adds a WAIT watchdog
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_W         = ALU_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        opcode,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [DATA_W-1:0] mux_out1,
    input  logic [DATA_W-1:0] mux_out2,
    input  logic              mux_ready,
    output logic              mux_en,
    output logic [1:0]        mux_state,
    output logic [DATA_W-1:0] mux_value1,
    output logic [DATA_W-1:0] mux_value2,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result_hi,
    output logic [DATA_W-1:0] result_lo,
    output logic              error
);
    logic [2:0] state, state_nx;
    logic       expired;
    logic       accept;
    logic       capture;

    assign accept  = state == ST_IDLE && start;
    assign capture = state == ST_WAIT && mux_ready;
    assign mux_en  = state == ST_ISSUE || state == ST_WAIT;
    assign busy    = state != ST_IDLE;
    assign done    = state == ST_DONE || state == ST_ERR;

    // next state; ISSUE never looks at ready so a stale ready from the previous op is masked
    always_comb begin
        state_nx = state == ST_IDLE  ? (start ? ST_ISSUE : ST_IDLE) :
                   state == ST_ISSUE ? ST_WAIT :
                   state == ST_WAIT  ? (mux_ready ? ST_DONE : expired ? ST_ERR : ST_WAIT) :
                   ST_IDLE;
    end

    // state, latched request and captured results; Output2 is only sampled for MUL
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            mux_state  <= '0;
            mux_value1 <= '0;
            mux_value2 <= '0;
            result_hi  <= '0;
            result_lo  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                mux_state  <= opcode;
                mux_value1 <= operand_a;
                mux_value2 <= operand_b;
            end
            if (capture) begin
                result_hi <= is_mul(mux_state) ? mux_out1 : '0;
                result_lo <= is_mul(mux_state) ? mux_out2 : mux_out1;
            end
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    logic err_q;

    alu_seq_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != ST_WAIT),
        .enable (state == ST_WAIT),
        .expired(expired)
    );

    // sticky timeout flag, cleared by the next accepted request
    always_ff @(posedge clk) begin
        if (reset || accept) err_q <= 1'b0;
        else if (state == ST_WAIT && !mux_ready && expired) err_q <= 1'b1;
    end

    assign error = err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign expired = 1'b0;
    assign error   = 1'b0;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench with a behavioural multiplexer model
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] opcode = 2'd0;
    logic [7:0] operand_a = 8'd0;
    logic [7:0] operand_b = 8'd0;
    logic [7:0] mux_out1, mux_out2;
    logic       mux_ready;
    logic       mux_en, busy, done, error;
    logic [1:0] mux_state;
    logic [7:0] mux_value1, mux_value2, result_hi, result_lo;

    int checks = 0;
    int failures = 0;

    int   lat = 0;
    logic stale = 1'b0;
    int   en_cnt = 0;
    logic [15:0] prod;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(8), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .mux_out1(mux_out1), .mux_out2(mux_out2), .mux_ready(mux_ready),
        .mux_en(mux_en), .mux_state(mux_state), .mux_value1(mux_value1), .mux_value2(mux_value2),
        .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo), .error(error)
    );

    // multiplexer model: ready in the lat-th WAIT cycle (ISSUE is en cycle 0); lat=0 never
    always @(posedge clk) en_cnt <= mux_en ? en_cnt + 1 : 0;
    assign mux_ready = stale | (lat != 0 && mux_en && en_cnt == lat);
    assign prod = mux_value1 * mux_value2;
    assign mux_out1 = mux_state == 2'd0 ? mux_value1 + mux_value2 :
                      mux_state == 2'd1 ? mux_value1 - mux_value2 :
                      mux_state == 2'd2 ? prod[15:8] : 8'd0 - mux_value1;
    assign mux_out2 = mux_state == 2'd2 ? prod[7:0] : 8'bx;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit inject, output int cyc, output bit got_done);
        bit unstable = 0;
        opcode = op; operand_a = a; operand_b = b; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (mux_value1 !== a || mux_value2 !== b || mux_state !== op) unstable = 1;
            if (inject && cyc == 2) begin
                opcode = ~op; operand_a = 8'd99; operand_b = 8'd88; start = 1'b1;
            end else start = 1'b0;
            step();
            cyc++;
        end
        start = 1'b0;
        got_done = done;
        checks++;
        if (!got_done) begin
            failures++;
            $display("FAIL op_done_timeout: done=%b after %0d cycles, required 1", done, cyc);
        end
        checks++;
        if (unstable || mux_value1 !== a || mux_value2 !== b || mux_state !== op) begin
            failures++;
            $display("FAIL op_inputs_stable: v1=%0d v2=%0d st=%0d, required %0d %0d %0d",
                     mux_value1, mux_value2, mux_state, a, b, op);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++;
        if ({mux_en, busy, done, error} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl: en/busy/done/err=%b, required 0000", {mux_en, busy, done, error});
        end
        checks++;
        if ({result_hi, result_lo, mux_value1, mux_value2, mux_state} !== 34'd0) begin
            failures++;
            $display("FAIL reset_data: hi=%h lo=%h v1=%h v2=%h st=%h, required all 0",
                     result_hi, result_lo, mux_value1, mux_value2, mux_state);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_add();
        int c; bit d;
        lat = 2;
        do_op(2'd0, 8'd100, 8'd27, 0, c, d);
        checks++;
        if (c != 4) begin
            failures++;
            $display("FAIL add_latency: done at %0d, required 4", c);
        end
        checks++;
        if ({result_hi, result_lo, error} !== {8'd0, 8'd127, 1'b0}) begin
            failures++;
            $display("FAIL add_result: hi=%0d lo=%0d err=%b, required 0 127 0", result_hi, result_lo, error);
        end
        step();
        checks++;
        if ({done, busy, result_lo} !== {1'b0, 1'b0, 8'd127}) begin
            failures++;
            $display("FAIL add_after: done=%b busy=%b lo=%0d, required 0 0 127", done, busy, result_lo);
        end
    endtask

    task automatic test_back_to_back();
        int c; bit d; int low = 0;
        lat = 1;
        do_op(2'd1, 8'd50, 8'd20, 0, c, d);
        checks++;
        if ({result_hi, result_lo} !== {8'd0, 8'd30} || c != 3) begin
            failures++;
            $display("FAIL sub_result: hi=%0d lo=%0d cyc=%0d, required 0 30 3", result_hi, result_lo, c);
        end
        if (!mux_en) low++;
        step();
        if (!mux_en) low++;
        checks++;
        if (low != 2) begin
            failures++;
            $display("FAIL en_gap: mux_en low %0d cycles, required 2", low);
        end
        do_op(2'd3, 8'd5, 8'd0, 0, c, d);
        checks++;
        if ({result_hi, result_lo} !== {8'd0, 8'd251}) begin
            failures++;
            $display("FAIL neg_result: hi=%0d lo=%0d, required 0 251", result_hi, result_lo);
        end
        step();
    endtask

    task automatic test_mul_and_x();
        int c; bit d;
        lat = 1;
        do_op(2'd2, 8'd16, 8'd16, 0, c, d);
        checks++;
        if ({result_hi, result_lo} !== {8'd1, 8'd0}) begin
            failures++;
            $display("FAIL mul_result: hi=%0d lo=%0d, required 1 0", result_hi, result_lo);
        end
        step();
        do_op(2'd0, 8'd1, 8'd2, 0, c, d);
        checks++;
        if ($isunknown({result_hi, result_lo}) || {result_hi, result_lo} !== {8'd0, 8'd3}) begin
            failures++;
            $display("FAIL add_no_x: hi=%h lo=%h, required 00 03", result_hi, result_lo);
        end
        step();
    endtask

    task automatic test_stale_ready();
        int c; bit d;
        lat = 0;
        stale = 1'b1;
        do_op(2'd0, 8'd3, 8'd4, 0, c, d);
        stale = 1'b0;
        checks++;
        if (c != 3 || result_lo !== 8'd7) begin
            failures++;
            $display("FAIL stale_ready: done at %0d lo=%0d, required 3 7", c, result_lo);
        end
        step();
    endtask

    task automatic test_start_ignored();
        int c; bit d; int extra = 0;
        lat = 4;
        do_op(2'd0, 8'd10, 8'd20, 1, c, d);
        checks++;
        if (c != 6 || result_lo !== 8'd30) begin
            failures++;
            $display("FAIL busy_start: done at %0d lo=%0d, required 6 30", c, result_lo);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL single_done: %0d extra busy/done cycles, required 0", extra);
        end
    endtask

`ifdef ALU_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int c; bit d;
        lat = 0;
        do_op(2'd0, 8'd1, 8'd1, 0, c, d);
        checks++;
        if (c != 10 || error !== 1'b1 || {result_hi, result_lo} !== {8'd0, 8'd30}) begin
            failures++;
            $display("FAIL timeout: cyc=%0d err=%b hi=%0d lo=%0d, required 10 1 0 30", c, error, result_hi, result_lo);
        end
        step();
        checks++;
        if ({error, done, busy} !== 3'b100) begin
            failures++;
            $display("FAIL error_sticky: err/done/busy=%b, required 100", {error, done, busy});
        end
        lat = 1;
        do_op(2'd0, 8'd2, 8'd2, 0, c, d);
        checks++;
        if (error !== 1'b0 || result_lo !== 8'd4) begin
            failures++;
            $display("FAIL error_clear: err=%b lo=%0d, required 0 4", error, result_lo);
        end
        step();
    endtask
`endif

    task automatic test_reset_mid_op();
        int seen = 0;
        lat = 0;
        opcode = 2'd0; operand_a = 8'd7; operand_b = 8'd7; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        checks++;
        if (!(busy && mux_en)) begin
            failures++;
            $display("FAIL pre_reset_wait: busy=%b en=%b, required 1 1", busy, mux_en);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({mux_en, busy, done, error, result_hi, result_lo, mux_value1, mux_value2, mux_state} !== 38'd0) begin
            failures++;
            $display("FAIL reset_mid: en=%b busy=%b done=%b err=%b hi=%h lo=%h v1=%h v2=%h st=%h, required all 0",
                     mux_en, busy, done, error, result_hi, result_lo, mux_value1, mux_value2, mux_state);
        end
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_discard: %0d busy/done cycles after reset, required 0", seen);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_add();
        test_back_to_back();
        test_mul_and_x();
        test_stale_ready();
        test_start_ignored();
`ifdef ALU_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
